sysreg_spr_update_ctrl: RTL and testbench

- Write-side controller for the SPR (stack pointer) register.
- Accepts stack commands from execute: push, pop, set, adjust. Computes the new SPR value from the current SPR readback and checks it against the stack window.
- On success, issues a one-cycle regist pulse plus data to the SPR register and reports the memory access address to the load/store path.
- On a limit violation, reports a fault instead and leaves SPR unchanged.

---
 rtl/sysreg_spr_pkg.sv | 32 +++
 rtl/sysreg_spr_limit_check.sv | 82 ++++++++
 rtl/sysreg_spr_update_ctrl.sv | 134 +++++++++++++
 tb/tb_sysreg_spr_update_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sysreg_spr_pkg.sv
// ---------------------------------------------------------------------------
// sysreg_spr_pkg
// Shared encodings for the SPR (stack pointer) write-side controller:
//   - stack command encodings as driven by execute on iREQ_CMD
//   - fault codes reported on oFAULT_CODE
//   - controller FSM state encodings
// No ports; imported by sysreg_spr_limit_check and sysreg_spr_update_ctrl.
// ---------------------------------------------------------------------------
package sysreg_spr_pkg;

  typedef enum logic [1:0] {
    SPR_CMD_PUSH = 2'b00,
    SPR_CMD_POP  = 2'b01,
    SPR_CMD_SET  = 2'b10,
    SPR_CMD_ADJ  = 2'b11
  } spr_cmd_e;

  typedef enum logic [1:0] {
    SPR_FLT_NONE = 2'b00,
    SPR_FLT_OVF  = 2'b01,
    SPR_FLT_UDF  = 2'b10,
    SPR_FLT_WRAP = 2'b11
  } spr_flt_e;

  typedef enum logic [1:0] {
    SPR_ST_IDLE   = 2'b00,
    SPR_ST_CALC   = 2'b01,
    SPR_ST_COMMIT = 2'b10,
    SPR_ST_FAULT  = 2'b11
  } spr_state_e;

endpackage

// File: rtl/sysreg_spr_limit_check.sv
// ---------------------------------------------------------------------------
// sysreg_spr_limit_check
// Purely combinational next-SPR calculation and stack window check.
//   cmd_i    : stack command (push/pop/set/adjust)
//   sp_i     : current SPR value
//   data_i   : set value or two's-complement adjust offset
//   base_i   : highest legal SPR value (inclusive)
//   limit_i  : lowest legal SPR value (inclusive)
//   new_o    : candidate new SPR value (modulo 2^N)
//   addr_o   : memory access address for the command
//   code_o   : fault code, wrap > overflow > underflow priority
// ---------------------------------------------------------------------------
module sysreg_spr_limit_check
  import sysreg_spr_pkg::*;
#(
  parameter int N          = 32,
  parameter int WORD_BYTES = 4
) (
  input  spr_cmd_e         cmd_i,
  input  logic [N-1:0]     sp_i,
  input  logic [N-1:0]     data_i,
  input  logic [N-1:0]     base_i,
  input  logic [N-1:0]     limit_i,
  output logic [N-1:0]     new_o,
  output logic [N-1:0]     addr_o,
  output spr_flt_e         code_o
);

  localparam logic [N:0] STEP = (N+1)'(WORD_BYTES);

  logic [N:0]   sum;
  logic [N-1:0] nxt;
  logic         wrap;
  logic signed [N-1:0] ofs_s;

  assign ofs_s = data_i;

  always_comb begin
    sum  = '0;
    nxt  = sp_i;
    wrap = 1'b0;
    unique case (cmd_i)
      SPR_CMD_PUSH: begin
        // Extra top bit captures the borrow out of sp - step.
        sum  = {1'b0, sp_i} - STEP;
        nxt  = sum[N-1:0];
        wrap = sum[N];
      end
      SPR_CMD_POP: begin
        sum  = {1'b0, sp_i} + STEP;
        nxt  = sum[N-1:0];
        wrap = sum[N];
      end
      SPR_CMD_SET: begin
        nxt  = data_i;
      end
      SPR_CMD_ADJ: begin
        // Adding a negative offset as unsigned must carry out; adding a
        // positive one must not. Any other combination wrapped the stack.
        sum  = {1'b0, sp_i} + {1'b0, data_i};
        nxt  = sum[N-1:0];
        wrap = sum[N] ^ (ofs_s < 0);
      end
      default: ;
    endcase
  end

  always_comb begin
    new_o = nxt;
    // Pop accesses the slot being released; everything else uses the new SP.
    addr_o = (cmd_i == SPR_CMD_POP) ? sp_i : nxt;
    if (wrap)
      code_o = SPR_FLT_WRAP;
    else if (nxt < limit_i)
      code_o = SPR_FLT_OVF;
    else if (nxt > base_i)
      code_o = SPR_FLT_UDF;
    else
      code_o = SPR_FLT_NONE;
  end

endmodule

// File: rtl/sysreg_spr_update_ctrl.sv
// ---------------------------------------------------------------------------
// sysreg_spr_update_ctrl
// Write-side controller for the SPR register. Accepts push/pop/set/adjust
// from execute, computes the new SPR against a latched stack window and
// either writes SPR (regist strobe + done pulse with access address) or
// reports a fault, leaving SPR untouched.
//   iCLOCK, iRESET_SYNC        : clock, synchronous active-high reset
//   iFLUSH                     : abort any in-flight command
//   iREQ_VALID/oREQ_BUSY       : request handshake
//   iREQ_CMD, iREQ_DATA        : command and operand
//   iSPR_DATA                  : current SPR readback
//   iSTACK_BASE, iSTACK_LIMIT  : inclusive legal SPR window (high, low)
//   oREGIST_REQ, oREGIST_DATA  : one-cycle SPR write
//   oDONE_VALID, oDONE_ADDR    : one-cycle completion + access address
//   oFAULT_VALID, oFAULT_CODE  : one-cycle fault report
// ---------------------------------------------------------------------------
module sysreg_spr_update_ctrl
  import sysreg_spr_pkg::*;
#(
  parameter int N          = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic         iCLOCK,
  input  logic         iRESET_SYNC,
  input  logic         iFLUSH,
  input  logic         iREQ_VALID,
  output logic         oREQ_BUSY,
  input  logic [1:0]   iREQ_CMD,
  input  logic [N-1:0] iREQ_DATA,
  input  logic [N-1:0] iSPR_DATA,
  input  logic [N-1:0] iSTACK_BASE,
  input  logic [N-1:0] iSTACK_LIMIT,
  output logic         oREGIST_REQ,
  output logic [N-1:0] oREGIST_DATA,
  output logic         oDONE_VALID,
  output logic [N-1:0] oDONE_ADDR,
  output logic         oFAULT_VALID,
  output logic [1:0]   oFAULT_CODE
);

  spr_state_e   state_q;

  // Operands captured at accept
  spr_cmd_e     cmd_q;
  logic [N-1:0] data_q;
  logic [N-1:0] sp_q;
  logic [N-1:0] base_q;
  logic [N-1:0] limit_q;

  // Results captured in CALC
  logic [N-1:0] new_q;
  logic [N-1:0] addr_q;
  spr_flt_e     code_q;

  logic [N-1:0] new_w;
  logic [N-1:0] addr_w;
  spr_flt_e     code_w;
  logic         accept;
  logic         strobe_ok;

  assign oREQ_BUSY = (state_q != SPR_ST_IDLE);
  assign accept    = iREQ_VALID & ~oREQ_BUSY & ~iFLUSH;

  sysreg_spr_limit_check #(
    .N          (N),
    .WORD_BYTES (WORD_BYTES)
  ) u_limit_check (
    .cmd_i   (cmd_q),
    .sp_i    (sp_q),
    .data_i  (data_q),
    .base_i  (base_q),
    .limit_i (limit_q),
    .new_o   (new_w),
    .addr_o  (addr_w),
    .code_o  (code_w)
  );

  // Control: FSM, the only state that needs reset
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q <= SPR_ST_IDLE;
    end else begin
      unique case (state_q)
        SPR_ST_IDLE: begin
          if (accept)
            state_q <= SPR_ST_CALC;
        end
        SPR_ST_CALC: begin
          if (iFLUSH)
            state_q <= SPR_ST_IDLE;
          else if (code_w != SPR_FLT_NONE)
            state_q <= SPR_ST_FAULT;
          else
            state_q <= SPR_ST_COMMIT;
        end
        SPR_ST_COMMIT: state_q <= SPR_ST_IDLE;
        SPR_ST_FAULT:  state_q <= SPR_ST_IDLE;
        default:       state_q <= SPR_ST_IDLE;
      endcase
    end
  end

  // Stage 0 -> 1: latch operands on accept
  always_ff @(posedge iCLOCK) begin
    if (accept) begin
      cmd_q   <= spr_cmd_e'(iREQ_CMD);
      data_q  <= iREQ_DATA;
      sp_q    <= iSPR_DATA;
      base_q  <= iSTACK_BASE;
      limit_q <= iSTACK_LIMIT;
    end
  end

  // Stage 1 -> 2: register computed value, address and fault
  always_ff @(posedge iCLOCK) begin
    if (state_q == SPR_ST_CALC) begin
      new_q  <= new_w;
      addr_q <= addr_w;
      code_q <= code_w;
    end
  end

  // Strobes come from registered state; flush or reset in the strobe cycle
  // must suppress them immediately so SPR is never written on an abort.
  assign strobe_ok    = ~iRESET_SYNC & ~iFLUSH;
  assign oREGIST_REQ  = (state_q == SPR_ST_COMMIT) & strobe_ok;
  assign oDONE_VALID  = oREGIST_REQ;
  assign oFAULT_VALID = (state_q == SPR_ST_FAULT) & strobe_ok;

  assign oREGIST_DATA = oREGIST_REQ  ? new_q  : '0;
  assign oDONE_ADDR   = oDONE_VALID  ? addr_q : '0;
  assign oFAULT_CODE  = oFAULT_VALID ? code_q : SPR_FLT_NONE;

endmodule

// File: tb/tb_sysreg_spr_update_ctrl.sv
module tb_sysreg_spr_update_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_busy;
  logic [1:0]  req_cmd;
  logic [31:0] req_data;
  logic [31:0] spr_data;
  logic [31:0] stk_base;
  logic [31:0] stk_limit;
  logic        regist_req;
  logic [31:0] regist_data;
  logic        done_valid;
  logic [31:0] done_addr;
  logic        fault_valid;
  logic [1:0]  fault_code;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sysreg_spr_update_ctrl #(
    .N          (32),
    .WORD_BYTES (4)
  ) dut (
    .iCLOCK       (clk),
    .iRESET_SYNC  (rst),
    .iFLUSH       (flush),
    .iREQ_VALID   (req_valid),
    .oREQ_BUSY    (req_busy),
    .iREQ_CMD     (req_cmd),
    .iREQ_DATA    (req_data),
    .iSPR_DATA    (spr_data),
    .iSTACK_BASE  (stk_base),
    .iSTACK_LIMIT (stk_limit),
    .oREGIST_REQ  (regist_req),
    .oREGIST_DATA (regist_data),
    .oDONE_VALID  (done_valid),
    .oDONE_ADDR   (done_addr),
    .oFAULT_VALID (fault_valid),
    .oFAULT_CODE  (fault_code)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "/regist"}, regist_req, 0);
    chk({tag, "/rdata"},  regist_data, 0);
    chk({tag, "/done"},   done_valid, 0);
    chk({tag, "/daddr"},  done_addr, 0);
    chk({tag, "/fault"},  fault_valid, 0);
    chk({tag, "/fcode"},  fault_code, 0);
  endtask

  // Full command: accept at T, check busy at T+1, result at T+2, idle at T+3.
  // Operands are scrambled after accept to prove they were latched.
  task automatic run_cmd(input string tag, input logic [1:0] cmd, input logic [31:0] data,
                         input logic [31:0] sp, input logic [31:0] base, input logic [31:0] limit,
                         input logic exp_ok, input logic [31:0] exp_new, input logic [31:0] exp_addr,
                         input logic [1:0] exp_code);
    req_cmd = cmd; req_data = data; spr_data = sp; stk_base = base; stk_limit = limit;
    req_valid = 1'b1;
    chk({tag, "/busyT"}, req_busy, 0);
    tick();
    req_valid = 1'b0;
    req_data = ~data; spr_data = 32'hDEAD_BEEF; stk_base = 32'h0; stk_limit = 32'hFFFF_FFFF;
    chk({tag, "/busyT1"}, req_busy, 1);
    chk({tag, "/regT1"}, regist_req, 0);
    tick();
    chk({tag, "/busyT2"}, req_busy, 1);
    chk({tag, "/regist"}, regist_req, exp_ok);
    chk({tag, "/rdata"},  regist_data, exp_ok ? exp_new : 32'h0);
    chk({tag, "/done"},   done_valid, exp_ok);
    chk({tag, "/daddr"},  done_addr, exp_ok ? exp_addr : 32'h0);
    chk({tag, "/fault"},  fault_valid, !exp_ok);
    chk({tag, "/fcode"},  fault_code, exp_ok ? 2'b00 : exp_code);
    tick();
    chk({tag, "/busyT3"}, req_busy, 0);
    chk({tag, "/idleT3"}, regist_req | fault_valid, 0);
    spr_data = sp;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b1; req_cmd = 2'b00;
    req_data = 32'h0; spr_data = 32'h1000; stk_base = 32'h1000; stk_limit = 32'h0800;

    // Reset, with a request held valid: reset must win
    tick();
    tick();
    chk("rst/busy", req_busy, 0);
    chk_quiet("rst");
    req_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("rst_rel/busy", req_busy, 0);
    chk_quiet("rst_rel");

    // Directed vectors
    run_cmd("push",     2'b00, 32'h0,         32'h0000_1000, 32'h1000, 32'h0800, 1, 32'h0FFC, 32'h0FFC, 2'b00);
    run_cmd("pop",      2'b01, 32'h0,         32'h0000_0FFC, 32'h1000, 32'h0800, 1, 32'h1000, 32'h0FFC, 2'b00);
    run_cmd("pop_udf",  2'b01, 32'h0,         32'h0000_1000, 32'h1000, 32'h0800, 0, 32'h0,    32'h0,    2'b10);
    run_cmd("push_ovf", 2'b00, 32'h0,         32'h0000_0800, 32'h1000, 32'h0800, 0, 32'h0,    32'h0,    2'b01);
    run_cmd("push_wrp", 2'b00, 32'h0,         32'h0000_0000, 32'h1000, 32'h0000, 0, 32'h0,    32'h0,    2'b11);
    run_cmd("push_lim", 2'b00, 32'h0,         32'h0000_0804, 32'h1000, 32'h0800, 1, 32'h0800, 32'h0800, 2'b00);
    run_cmd("adj_neg",  2'b11, 32'hFFFF_FFF0, 32'h0000_1000, 32'h1000, 32'h0800, 1, 32'h0FF0, 32'h0FF0, 2'b00);
    run_cmd("adj_wrp",  2'b11, 32'h0000_0010, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'h0, 0, 32'h0,  32'h0,    2'b11);
    run_cmd("adj_nwrp", 2'b11, 32'hFFFF_FFF0, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0, 0, 32'h0,  32'h0,    2'b11);
    run_cmd("pop_wrp",  2'b01, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0, 0, 32'h0,  32'h0,    2'b11);
    run_cmd("set",      2'b10, 32'h0000_0900, 32'h0000_1000, 32'h1000, 32'h0800, 1, 32'h0900, 32'h0900, 2'b00);
    run_cmd("set_base", 2'b10, 32'h0000_1000, 32'h0000_0900, 32'h1000, 32'h0800, 1, 32'h1000, 32'h1000, 2'b00);
    run_cmd("set_udf",  2'b10, 32'h0000_1004, 32'h0000_0900, 32'h1000, 32'h0800, 0, 32'h0,    32'h0,    2'b10);

    // Flush while IDLE drops the request
    req_cmd = 2'b00; spr_data = 32'h1000; stk_base = 32'h1000; stk_limit = 32'h0800;
    req_valid = 1'b1; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    chk("flidle/busy", req_busy, 0);

    // Flush in CALC
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    chk("flcalc/busy", req_busy, 1);
    chk_quiet("flcalc/T1");
    tick();
    flush = 1'b0;
    chk("flcalc/busyT2", req_busy, 0);
    chk_quiet("flcalc/T2");
    tick();
    chk_quiet("flcalc/T3");
    run_cmd("after_fl", 2'b00, 32'h0, 32'h0000_1000, 32'h1000, 32'h0800, 1, 32'h0FFC, 32'h0FFC, 2'b00);

    // Flush in COMMIT suppresses the strobe that cycle
    req_cmd = 2'b00; spr_data = 32'h1000; stk_base = 32'h1000; stk_limit = 32'h0800;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    chk_quiet("flcommit");
    tick();
    flush = 1'b0;
    chk("flcommit/busy", req_busy, 0);

    // Reset in COMMIT
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk_quiet("rstcommit");
    tick();
    rst = 1'b0;
    chk("rstcommit/busy", req_busy, 0);
    chk_quiet("rstcommit/after");

    // Back-to-back pushes, request held valid, SPR updated by the bench
    req_cmd = 2'b00; spr_data = 32'h1000; stk_base = 32'h1000; stk_limit = 32'h0800;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp_sp;
      exp_sp = 32'h1000 - 32'(4 * (k + 1));
      chk("b2b/busyT", req_busy, 0);
      tick();
      chk("b2b/busyT1", req_busy, 1);
      chk("b2b/regT1", regist_req, 0);
      tick();
      chk("b2b/regist", regist_req, 1);
      chk("b2b/rdata", regist_data, exp_sp);
      chk("b2b/daddr", done_addr, exp_sp);
      tick();
      spr_data = exp_sp;
    end
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("b2b/end_busy", req_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
